queue2_unpacker: RTL and testbench
==================================

Name: queue2_unpacker

Overview:
- Reader/drain for a two-entry look-ahead queue: consumes WIDTH-bit words from the queue's status/read port and emits them as OUT_WIDTH-bit beats on a valid/ready stream.
- Sits between the bridge's word queue and a narrow serial or byte-wide transmit path.
- Uses the queue's second entry (data1) to load the next word in the same cycle it pops the current one, so back-to-back words stream with no bubble.

Parameters:
WIDTH, 32, queue word width; must be an integer multiple of OUT_WIDTH.
OUT_WIDTH, 8, output beat width.
MSB_FIRST, 1, 1 = most-significant beat first; 0 = least-significant beat first.
(local) BEATS = WIDTH/OUT_WIDTH; beat counter width = max(1, clog2(BEATS)).

Ports:
i_clk  input  1  clock; single clock domain.
i_rst_n  input  1  reset; synchronous, active-low.
i_q_vld  input  2  queue valid bits; legal values are 00, 01 and 11 only.
i_q_data1  input  WIDTH  queue entry 1 (next-after-head); meaningful only when i_q_vld[1]=1.
i_q_data0  input  WIDTH  queue head entry; meaningful only when i_q_vld[0]=1.
o_q_rd  output  1  queue pop strobe (combinational).
o_valid  output  1  output beat valid.
i_ready  input  1  downstream accepts the beat.
o_data  output  OUT_WIDTH  current beat.
o_last  output  1  current beat is the final beat of its word.
o_busy  output  1  a word is held (state SEND).

Behaviour:
- Reset (i_rst_n=0 at a clock edge):
  - state <= EMPTY; beat counter cnt <= 0; shift register sh <= 0.
  - o_valid=0, o_last=0, o_data=0, o_busy=0, o_q_rd=0 from the next cycle.
  - o_q_rd is forced to 0 during any cycle in which i_rst_n=0.
  - The queue is reset from the same reset net (inverted at integration), so no word survives reset on either side.
- States:
  - EMPTY: o_valid=0, o_q_rd=0. If i_q_vld[0]=1: sh <= i_q_data0, cnt <= 0, go to SEND. The word is loaded but not popped.
    - Latency: first beat is valid 1 cycle after i_q_vld[0] is first seen high.
  - SEND: o_valid=1, o_busy=1.
    - o_data = top OUT_WIDTH bits of sh when MSB_FIRST=1; bottom bits when MSB_FIRST=0.
    - o_last = (cnt == BEATS-1).
- Handshake:
  - A beat transfers when o_valid && i_ready.
  - o_data and o_last must stay stable while o_valid && !i_ready.
  - On a transfer with !o_last: shift sh by OUT_WIDTH toward the emitting end (zero fill), cnt++.
  - On a transfer with o_last:
    - o_q_rd=1 in that same cycle. Pop strobe: o_q_rd = (state==SEND) && i_ready && o_last.
    - If i_q_vld==11: sh <= i_q_data1, cnt <= 0, stay in SEND (zero-bubble).
    - If i_q_vld==01: go to EMPTY.
  - The held word is always the queue head, so i_q_vld[0]=1 throughout SEND.
  - o_q_rd must never assert while i_q_vld==00; this is an assertion property.
- Simultaneous events:
  - A queue write arriving in the same cycle as the final-beat pop is the queue's responsibility.
  - The unpacker samples i_q_vld only in the current cycle and never looks at queue writes.
- BEATS=1: every transfer is a final beat. o_last stays 1 while valid, and a pop accompanies every accepted beat.
- Width rule: WIDTH % OUT_WIDTH != 0 is illegal; elaboration must fail via a generate-time error.
- Formal properties:
  - o_q_rd implies i_q_vld[0].
  - o_valid == (state==SEND).
  - cnt <= BEATS-1.
  - Beats transferred == BEATS × pops, checked at every word boundary.

Test Plan:
1. Hold i_rst_n=0 for 3 cycles with i_q_vld=01 -> o_valid, o_q_rd, o_data, o_last and o_busy all 0; no pop.
2. i_q_vld=01, i_q_data0=0xA1B2C3D4, i_ready=1 -> starting 1 cycle later, beats A1, B2, C3, D4 on consecutive cycles; o_last and o_q_rd high only with D4; o_valid=0 on the following cycle.
3. i_q_vld=11, data0=0x11223344, data1=0x55667788, i_ready=1; after the first pop drive i_q_vld=01 with data0=0x55667788 -> 8 back-to-back beats 11 22 33 44 55 66 77 88 with no bubble; exactly two o_q_rd pulses (on 44 and 88).
4. Single word 0xA1B2C3D4; drop i_ready for 3 cycles while B2 is presented -> o_data=B2 and o_valid=1 held stable for those 3 cycles; no pop until D4 is accepted.
5. Assert i_rst_n=0 while beat C3 is presented -> next cycle o_valid=0; no o_q_rd pulse ever issued for that word.
6. MSB_FIRST=0 with word 0xA1B2C3D4 -> beats D4, C3, B2, A1; o_last on A1.

Source files
------------

// File: rtl/queue2_unpacker.sv
// queue2_unpacker: drains a two-entry look-ahead word queue and serialises each
// WIDTH-bit word into OUT_WIDTH-bit beats on a valid/ready stream. The second
// queue entry is loaded in the same cycle the head is popped, so consecutive
// words stream without a bubble.
module queue2_unpacker #(
   parameter int WIDTH     = 32,
   parameter int OUT_WIDTH = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic [1:0]           i_q_vld,
   input  logic [WIDTH-1:0]     i_q_data1,
   input  logic [WIDTH-1:0]     i_q_data0,
   output logic                 o_q_rd,
   output logic                 o_valid,
   input  logic                 i_ready,
   output logic [OUT_WIDTH-1:0] o_data,
   output logic                 o_last,
   output logic                 o_busy
);

   localparam int              BEATS    = WIDTH / OUT_WIDTH;
   localparam int              CNT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

   localparam logic [0:0] S_EMPTY = 1'b0;
   localparam logic [0:0] S_SEND  = 1'b1;

   // Reject word/beat geometries that cannot be split evenly.
   generate
      if ((OUT_WIDTH < 1) || (WIDTH < OUT_WIDTH) || ((WIDTH % OUT_WIDTH) != 0)) begin : g_width_check
         $error("queue2_unpacker: WIDTH must be a positive multiple of OUT_WIDTH");
      end
   endgenerate

   logic [0:0]           state;
   logic [CNT_W-1:0]     cnt;
   logic [WIDTH-1:0]     sh;
   logic [WIDTH-1:0]     sh_shifted;
   logic [OUT_WIDTH-1:0] beat;
   logic                 last_beat;
   logic                 xfer;

   assign o_valid   = (state == S_SEND);
   assign o_busy    = o_valid;
   assign last_beat = (cnt == LAST_CNT);
   assign o_last    = o_valid && last_beat;
   assign o_data    = o_valid ? beat : '0;
   assign xfer      = o_valid && i_ready;
   // The pop is gated by reset so a word caught mid-flight is never popped.
   assign o_q_rd    = i_rst_n && xfer && last_beat;

   // Select the emitting end of the shift register and its zero-filled successor.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      beat       = '0;
      sh_shifted = '0;
      if (MSB_FIRST) begin
         beat       = sh[WIDTH-1 -: OUT_WIDTH];
         sh_shifted = sh << OUT_WIDTH;
      end else begin
         beat       = sh[OUT_WIDTH-1:0];
         sh_shifted = sh >> OUT_WIDTH;
      end
   end

   // Word load, beat shifting and the EMPTY/SEND sequencing.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         // NOTE: state is updated with <= only, so every register samples pre-edge values.
         state <= S_EMPTY;
         cnt   <= '0;
         // NOTE: sh is a single datapath register (not a memory array), cleared so no stale word leaks out.
         sh    <= '0;
      end else begin
         case (state)
            S_EMPTY: begin
               if (i_q_vld[0]) begin
                  sh    <= i_q_data0;
                  cnt   <= '0;
                  state <= S_SEND;
               end
            end
            default: begin
               if (xfer) begin
                  if (last_beat) begin
                     if (i_q_vld[1]) begin
                        sh  <= i_q_data1;
                        cnt <= '0;
                     end else begin
                        state <= S_EMPTY;
                     end
                  end else begin
                     sh  <= sh_shifted;
                     cnt <= cnt + CNT_W'(1);
                  end
               end
            end
         endcase
      end
   end

`ifndef SYNTHESIS
   // Protocol and structural invariants.
   a_pop_needs_head : assert property (@(posedge i_clk) disable iff (!i_rst_n) o_q_rd |-> i_q_vld[0]);
   a_valid_is_send  : assert property (@(posedge i_clk) disable iff (!i_rst_n) o_valid == (state == S_SEND));
   a_cnt_in_range   : assert property (@(posedge i_clk) disable iff (!i_rst_n) cnt <= LAST_CNT);
`endif

endmodule

// File: tb/tb_queue2_unpacker.sv
// Bench for queue2_unpacker: a two-entry word queue model feeds two instances
// (MSB-first and LSB-first) from the same inputs; every accepted beat is checked
// against beat lists computed arithmetically from the pushed words.
module tb_queue2_unpacker;

   localparam int W     = 32;
   localparam int OW    = 8;
   localparam int BEATS = W / OW;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          ready = 1'b0;
   logic [1:0]    q_vld = 2'b00;
   logic [W-1:0]  q_data0 = '0;
   logic [W-1:0]  q_data1 = '0;

   logic          rd_m, valid_m, last_m, busy_m;
   logic [OW-1:0] data_m;
   logic          rd_l, valid_l, last_l, busy_l;
   logic [OW-1:0] data_l;

   always #5 clk = ~clk;

   queue2_unpacker #(.WIDTH(W), .OUT_WIDTH(OW), .MSB_FIRST(1'b1)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_q_vld(q_vld), .i_q_data1(q_data1), .i_q_data0(q_data0),
      .o_q_rd(rd_m), .o_valid(valid_m), .i_ready(ready), .o_data(data_m), .o_last(last_m), .o_busy(busy_m)
   );

   queue2_unpacker #(.WIDTH(W), .OUT_WIDTH(OW), .MSB_FIRST(1'b0)) dut_lsb (
      .i_clk(clk), .i_rst_n(rst_n), .i_q_vld(q_vld), .i_q_data1(q_data1), .i_q_data0(q_data0),
      .o_q_rd(rd_l), .o_valid(valid_l), .i_ready(ready), .o_data(data_l), .o_last(last_l), .o_busy(busy_l)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Queue model and expected beat streams ({last, data}).
   logic [W-1:0]  q[$];
   logic [OW:0]   exp_m[$];
   logic [OW:0]   exp_l[$];

   bit            rst_drv = 1'b0;
   bit            rdy = 1'b0;
   logic          s_valid, s_last, s_rd, s_busy, s_valid_l, s_last_l, s_rd_l;
   logic [OW-1:0] s_data, s_data_l;
   bit            stall_prev = 1'b0;
   logic [OW-1:0] prev_data;
   logic          prev_last;
   int            beats = 0;
   int            pops = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [OW-1:0] beat_of(input logic [W-1:0] w, input int k, input bit msb);
      int sft;
      sft = msb ? (W - OW * (k + 1)) : (OW * k);
      return OW'(w >> sft);
   endfunction

   task automatic push_word(input logic [W-1:0] w);
      q.push_back(w);
      for (int k = 0; k < BEATS; k++) begin
         exp_m.push_back({(k == BEATS - 1), beat_of(w, k, 1'b1)});
         exp_l.push_back({(k == BEATS - 1), beat_of(w, k, 1'b0)});
      end
   endtask

   // One clock cycle: drive on the falling edge, sample 1 ns later, then let the
   // rising edge commit and retire a popped word from the queue model.
   task automatic step();
      logic [OW:0] e, el;
      @(negedge clk);
      rst_n   = rst_drv;
      ready   = rdy;
      q_vld   = (q.size() >= 2) ? 2'b11 : (q.size() == 1) ? 2'b01 : 2'b00;
      q_data0 = (q.size() > 0) ? q[0] : '0;
      q_data1 = (q.size() > 1) ? q[1] : '0;
      #1;
      s_valid = valid_m; s_last = last_m; s_rd = rd_m; s_busy = busy_m; s_data = data_m;
      s_valid_l = valid_l; s_last_l = last_l; s_rd_l = rd_l; s_data_l = data_l;
      if (!rst_drv) begin
         check("rst_no_rd", s_rd, 0);
         check("rst_no_rd_lsb", s_rd_l, 0);
      end else begin
         if (stall_prev) begin
            check("stall_valid", s_valid, 1);
            check("stall_data", s_data, prev_data);
            check("stall_last", s_last, prev_last);
         end
         check("busy_eq_valid", s_busy, s_valid);
         check("lsb_valid", s_valid_l, s_valid);
         if (exp_m.size() == 0) check("idle_valid", s_valid, 0);
         if (s_valid && rdy && exp_m.size() > 0) begin
            e  = exp_m.pop_front();
            el = exp_l.pop_front();
            check("beat_data", s_data, e[OW-1:0]);
            check("beat_last", s_last, e[OW]);
            check("beat_rd", s_rd, e[OW]);
            check("beat_data_lsb", s_data_l, el[OW-1:0]);
            check("beat_last_lsb", s_last_l, el[OW]);
            check("beat_rd_lsb", s_rd_l, el[OW]);
            beats++;
         end else begin
            check("no_rd", s_rd, 0);
            check("no_rd_lsb", s_rd_l, 0);
         end
         if (s_rd) begin
            pops++;
            check("beats_vs_pops", beats, pops * BEATS);
         end
      end
      stall_prev = rst_drv && s_valid && !rdy;
      prev_data  = s_data;
      prev_last  = s_last;
      @(posedge clk);
      if (rst_drv && s_rd && q.size() > 0) void'(q.pop_front());
   endtask

   // Hold reset for n cycles; queue and expectations are cleared with it.
   task automatic do_reset(input int n, input bit skip_first);
      rst_drv = 1'b0;
      for (int i = 0; i < n; i++) begin
         step();
         if (i > 0 || !skip_first) begin
            check("rst_valid", s_valid, 0);
            check("rst_last", s_last, 0);
            check("rst_data", s_data, 0);
            check("rst_busy", s_busy, 0);
            check("rst_valid_lsb", s_valid_l, 0);
         end
      end
      rst_drv = 1'b1;
      q.delete(); exp_m.delete(); exp_l.delete();
      beats = 0; pops = 0; stall_prev = 1'b0;
   endtask

   localparam logic [OW-1:0] T2M [BEATS] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
   localparam logic [OW-1:0] T2L [BEATS] = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};

   initial begin
      int  rd_cnt;
      bit  rd_seen;

      // Reset held with a head entry visible.
      q.push_back(32'h0BAD_F00D);
      do_reset(4, 1'b1);

      // Single word, ready always high; both beat orders.
      rdy = 1'b1;
      push_word(32'hA1B2_C3D4);
      step();
      check("t2_latency", s_valid, 0);
      for (int k = 0; k < BEATS; k++) begin
         step();
         check("t2_valid", s_valid, 1);
         check("t2_data", s_data, T2M[k]);
         check("t2_last", s_last, (k == BEATS - 1));
         check("t2_rd", s_rd, (k == BEATS - 1));
         check("t6_data_lsb", s_data_l, T2L[k]);
         check("t6_last_lsb", s_last_l, (k == BEATS - 1));
      end
      step();
      check("t2_after", s_valid, 0);

      // Two queued words stream back to back.
      push_word(32'h1122_3344);
      push_word(32'h5566_7788);
      rd_cnt = 0;
      step();
      for (int k = 0; k < 2 * BEATS; k++) begin
         step();
         check("t3_valid", s_valid, 1);
         check("t3_data", s_data, OW'(8'h11 * (k + 1)));
         check("t3_rd", s_rd, (k == BEATS - 1) || (k == 2 * BEATS - 1));
         if (s_rd) rd_cnt++;
      end
      check("t3_pops", rd_cnt, 2);
      step();
      check("t3_after", s_valid, 0);

      // Backpressure while B2 is presented.
      push_word(32'hA1B2_C3D4);
      step();
      step();
      check("t4_a1", s_data, 8'hA1);
      rdy = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         check("t4_hold_valid", s_valid, 1);
         check("t4_hold_data", s_data, 8'hB2);
         check("t4_hold_rd", s_rd, 0);
      end
      rdy = 1'b1;
      for (int k = 1; k < BEATS; k++) begin
         step();
         check("t4_data", s_data, T2M[k]);
         check("t4_rd", s_rd, (k == BEATS - 1));
      end
      step();

      // Reset while C3 is presented: the word is never popped.
      push_word(32'hA1B2_C3D4);
      rd_seen = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         rd_seen |= s_rd;
      end
      check("t5_b2", s_data, 8'hB2);
      rst_drv = 1'b0;
      step();
      rd_seen |= s_rd;
      check("t5_c3", s_data, 8'hC3);
      do_reset(2, 1'b0);
      check("t5_no_pop", rd_seen, 0);

      // Randomized traffic against the queue/beat model.
      for (int c = 0; c < 3000; c++) begin
         rdy = ($urandom_range(0, 3) != 0);
         if (q.size() < 2 && $urandom_range(0, 2) == 0) push_word($urandom);
         if ($urandom_range(0, 599) == 0) do_reset(2, 1'b1);
         else step();
      end

      // Drain: every pushed word must come out.
      rdy = 1'b1;
      for (int c = 0; c < 4 * BEATS + 4; c++) step();
      check("drain_beats", exp_m.size(), 0);
      check("drain_queue", q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
